// File: rtl/sprite_palette_lut_if.sv
// Lookup/write bus for the sprite palette LUT: write port, lookup request and registered colour result.
interface sprite_palette_lut_if #(
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned COLOR_W   = 8,
    parameter int unsigned NUM_BANKS = 4
);
    localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned RGB_W  = 3 * COLOR_W;

    logic              wr_en;
    logic [BANK_W-1:0] wr_bank;
    logic [IDX_W-1:0]  wr_idx;
    logic [RGB_W-1:0]  wr_rgb;

    logic              rd_valid_in;
    logic [BANK_W-1:0] rd_bank;
    logic [IDX_W-1:0]  rd_idx;
    logic [1:0]        dim;

    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
    logic               opaque;
    logic               rd_valid_out;

    // Game logic / sprite renderer side
    modport master (
        output wr_en, wr_bank, wr_idx, wr_rgb,
        output rd_valid_in, rd_bank, rd_idx, dim,
        input  red, green, blue, opaque, rd_valid_out
    );

    // Palette LUT side
    modport slave (
        input  wr_en, wr_bank, wr_idx, wr_rgb,
        input  rd_valid_in, rd_bank, rd_idx, dim,
        output red, green, blue, opaque, rd_valid_out
    );
endinterface

// File: rtl/sprite_palette_lut.sv
// Banked, run-time writable sprite colour LUT with a fixed 2-cycle lookup pipeline,
// transparency on a reserved index and per-request dimming.
module sprite_palette_lut #(
    parameter int unsigned IDX_W           = 4,
    parameter int unsigned COLOR_W         = 8,
    parameter int unsigned NUM_BANKS       = 4,
    parameter int unsigned TRANSPARENT_IDX = 0
) (
    input logic                 Clk,
    input logic                 Reset,
    sprite_palette_lut_if.slave bus
);
    localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned DEPTH  = 1 << IDX_W;
    localparam int unsigned RGB_W  = 3 * COLOR_W;
    localparam logic [BANK_W:0]  NUM_BANKS_L = (BANK_W + 1)'(NUM_BANKS);
    localparam logic [IDX_W-1:0] TRANSP_L    = IDX_W'(TRANSPARENT_IDX);

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    rgb_t mem [NUM_BANKS][DEPTH];

    logic              s1_valid;
    logic [BANK_W-1:0] s1_bank;
    logic [IDX_W-1:0]  s1_idx;
    logic [1:0]        s1_dim;

    logic               wr_ok_c;
    logic               rd_bank_ok_c;
    rgb_t               entry_c;
    logic [COLOR_W-1:0] red_c;
    logic [COLOR_W-1:0] green_c;
    logic [COLOR_W-1:0] blue_c;
    logic               opaque_c;

    // Map an 8-bit default channel onto COLOR_W bits: keep the MSBs, zero-pad below.
    function automatic logic [COLOR_W-1:0] scale_chan(input logic [7:0] c);
        logic [COLOR_W+7:0] t;
        t = {c, COLOR_W'(0)};
        return t[COLOR_W+7 -: COLOR_W];
    endfunction

    // Power-up contents of bank 0; unlisted entries are black.
    function automatic rgb_t default_entry(input int unsigned idx);
        logic [23:0] v;
        case (idx)
            0:       v = 24'hFFC0CB;
            1:       v = 24'h000000;
            2:       v = 24'h444653;
            3:       v = 24'hE90044;
            4:       v = 24'h57525E;
            5:       v = 24'h918594;
            6:       v = 24'h1E1F27;
            7:       v = 24'h373946;
            8:       v = 24'h3B405D;
            default: v = 24'h000000;
        endcase
        return '{r: scale_chan(v[23:16]), g: scale_chan(v[15:8]), b: scale_chan(v[7:0])};
    endfunction

    // Writes to a bank beyond NUM_BANKS are discarded.
    always_comb begin
        wr_ok_c = 1'b0;
        wr_ok_c = bus.wr_en && ({1'b0, bus.wr_bank} < NUM_BANKS_L);
    end

    // Palette storage: default table on reset, single write port otherwise.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    mem[b][i] <= (b == 0) ? default_entry(i) : '0;
                end
            end
        end else if (wr_ok_c) begin
            mem[bus.wr_bank][bus.wr_idx] <= rgb_t'(bus.wr_rgb);
        end
    end

    // Stage 1: capture the lookup request.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid <= 1'b0;
            s1_bank  <= '0;
            s1_idx   <= '0;
            s1_dim   <= '0;
        end else begin
            s1_valid <= bus.rd_valid_in;
            s1_bank  <= bus.rd_bank;
            s1_idx   <= bus.rd_idx;
            s1_dim   <= bus.dim;
        end
    end

    // Array read and colour shaping for the request held in stage 1.
    always_comb begin
        entry_c      = '0;
        rd_bank_ok_c = 1'b0;
        red_c        = '0;
        green_c      = '0;
        blue_c       = '0;
        opaque_c     = 1'b0;
        rd_bank_ok_c = {1'b0, s1_bank} < NUM_BANKS_L;
        if (rd_bank_ok_c) begin
            entry_c = mem[s1_bank][s1_idx];
        end
        if (rd_bank_ok_c && (s1_idx != TRANSP_L)) begin
            red_c    = entry_c.r >> s1_dim;
            green_c  = entry_c.g >> s1_dim;
            blue_c   = entry_c.b >> s1_dim;
            opaque_c = 1'b1;
        end
    end

    // Stage 2: register results; colour outputs hold while no request is in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bus.red          <= '0;
            bus.green        <= '0;
            bus.blue         <= '0;
            bus.opaque       <= 1'b0;
            bus.rd_valid_out <= 1'b0;
        end else begin
            bus.rd_valid_out <= s1_valid;
            if (s1_valid) begin
                bus.red    <= red_c;
                bus.green  <= green_c;
                bus.blue   <= blue_c;
                bus.opaque <= opaque_c;
            end
        end
    end
endmodule

// File: tb/tb_sprite_palette_lut.sv
// Scoreboard bench for sprite_palette_lut: reference palette model, expected pixels queued at issue.
module tb_sprite_palette_lut;
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       op;
    } pix_t;

    logic Clk;
    logic Reset;
    int   n_tests;
    int   n_fail;
    pix_t exp_q[$];
    pix_t last;
    logic [23:0] model [4][16];
    logic rst_edge;

    sprite_palette_lut_if bus ();

    sprite_palette_lut dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 16; i++)
                model[2'(b)][4'(i)] = 24'h0;
        model[0][0] = 24'hFFC0CB;
        model[0][1] = 24'h000000;
        model[0][2] = 24'h444653;
        model[0][3] = 24'hE90044;
        model[0][4] = 24'h57525E;
        model[0][5] = 24'h918594;
        model[0][6] = 24'h1E1F27;
        model[0][7] = 24'h373946;
        model[0][8] = 24'h3B405D;
    endtask

    function automatic pix_t expect_pix(input logic [1:0] b, input logic [3:0] i, input logic [1:0] d);
        pix_t p;
        logic [23:0] e;
        e = model[b][i];
        p = '0;
        if (i != 4'd0) begin
            p.r  = e[23:16] >> d;
            p.g  = e[15:8] >> d;
            p.b  = e[7:0] >> d;
            p.op = 1'b1;
        end
        return p;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
        bus.wr_en       = 1'b0;
        bus.rd_valid_in = 1'b0;
    endtask

    task automatic wr(input logic [1:0] b, input logic [3:0] i, input logic [23:0] rgb);
        bus.wr_en   = 1'b1;
        bus.wr_bank = b;
        bus.wr_idx  = i;
        bus.wr_rgb  = rgb;
        model[b][i] = rgb;
    endtask

    task automatic rd(input logic [1:0] b, input logic [3:0] i, input logic [1:0] d, input bit push);
        bus.rd_valid_in = 1'b1;
        bus.rd_bank     = b;
        bus.rd_idx      = i;
        bus.dim         = d;
        if (push) exp_q.push_back(expect_pix(b, i, d));
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) step();
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
        step();
    endtask

    // Output monitor: sample 2 time units after each rising edge.
    always @(posedge Clk) begin
        pix_t e;
        rst_edge = Reset;
        #2;
        if (rst_edge) begin
            last = '0;
            check_eq("rst_valid", 32'(bus.rd_valid_out), 32'd0);
            check_eq("rst_rgb", 32'({bus.red, bus.green, bus.blue}), 32'd0);
            check_eq("rst_opaque", 32'(bus.opaque), 32'd0);
        end else if (bus.rd_valid_out) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_valid", 32'(bus.rd_valid_out), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("red", 32'(bus.red), 32'(e.r));
                check_eq("green", 32'(bus.green), 32'(e.g));
                check_eq("blue", 32'(bus.blue), 32'(e.b));
                check_eq("opaque", 32'(bus.opaque), 32'(e.op));
                last = e;
            end
        end else begin
            check_eq("hold_rgb", 32'({bus.red, bus.green, bus.blue}), 32'({last.r, last.g, last.b}));
            check_eq("hold_opaque", 32'(bus.opaque), 32'(last.op));
        end
    end

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        last            = '0;
        Reset           = 1'b1;
        bus.wr_en       = 1'b0;
        bus.wr_bank     = '0;
        bus.wr_idx      = '0;
        bus.wr_rgb      = '0;
        bus.rd_valid_in = 1'b0;
        bus.rd_bank     = '0;
        bus.rd_idx      = '0;
        bus.dim         = '0;
        model_reset();
        repeat (3) step();
        Reset = 1'b0;
        step();

        // Default table lookup and transparent index
        rd(2'd0, 4'd3, 2'd0, 1'b1);
        step();
        step();
        step();
        rd(2'd0, 4'd0, 2'd0, 1'b1);
        step();
        drain();

        // Read one cycle before a write edge sees the old value; the next cycle sees the new one
        rd(2'd2, 4'd5, 2'd0, 1'b1);
        step();
        wr(2'd2, 4'd5, 24'h102030);
        step();
        rd(2'd2, 4'd5, 2'd0, 1'b1);
        step();
        // Write and request registered on the same edge: write is visible
        wr(2'd1, 4'd7, 24'hABCDEF);
        rd(2'd1, 4'd7, 2'd1, 1'b1);
        step();
        drain();

        // Dimming
        rd(2'd0, 4'd5, 2'd2, 1'b1);
        step();
        rd(2'd0, 4'd5, 2'd3, 1'b1);
        step();
        drain();

        // Back-to-back stream of the default table
        for (int i = 1; i <= 8; i++) begin
            rd(2'd0, 4'(i), 2'd0, 1'b1);
            step();
        end
        drain();

        // Random writes and reads
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 1)
                wr(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 24'($urandom));
            if ($urandom_range(0, 3) != 0)
                rd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'b1);
            step();
        end
        drain();

        // Reset in the cycle after a request is registered flushes it
        rd(2'd2, 4'd5, 2'd0, 1'b0);
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        exp_q.delete();
        model_reset();
        step();
        step();
        rd(2'd2, 4'd5, 2'd0, 1'b1);
        step();
        rd(2'd0, 4'd3, 2'd0, 1'b1);
        step();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
